decode_stage: RTL and testbench

- Instruction-decode (ID) stage of the pipelined NN CPU.
- Consumes the IF/ID register contents (instruction, PC, valid) from fetch.
- Decodes fields, detects load-use and halt hazards, and drives the stall back to fetch; fetch gates PCEn with the stall.
- Registers the decoded result into the ID/EX pipeline register for execute.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/hazard_unit.sv | 34 +++
 rtl/decode_stage.sv | 134 +++++++++++++
 tb/tb_decode_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the NN CPU: opcodes, field positions and
// opcode-class predicates used by the decode stage and its hazard logic.
package cpu_pkg;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RD_HI  = 25;
   localparam int RD_LO  = 21;
   localparam int RS_HI  = 20;
   localparam int RS_LO  = 16;
   localparam int RT_HI  = 15;
   localparam int RT_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_MUL  = 6'h03;
   localparam logic [5:0] OP_MAC  = 6'h04;
   localparam logic [5:0] OP_LD   = 6'h05;
   localparam logic [5:0] OP_ST   = 6'h06;
   localparam logic [5:0] OP_ADDI = 6'h07;
   localparam logic [5:0] OP_HALT = 6'h3F;

   typedef enum logic {
      RUN_ST  = 1'b0,
      HALT_ST = 1'b1
   } run_state_e;

   function automatic logic is_legal(input logic [5:0] op);
      return (op inside {OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_MAC,
                         OP_LD, OP_ST, OP_ADDI, OP_HALT});
   endfunction

   function automatic logic writes_rd(input logic [5:0] op);
      return (op inside {OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_LD, OP_ADDI});
   endfunction

   function automatic logic uses_rt(input logic [5:0] op);
      return (op inside {OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_ST});
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use compare between the instruction in ID and the load in ID/EX,
// plus the fetch stall that combines it with the halted condition.
module hazard_unit
   import cpu_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int OP_W   = 6
) (
   input  logic              rst,
   input  logic              halted,
   input  logic              valid_d,
   input  logic [OP_W-1:0]   op,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic              ex_valid,
   input  logic [OP_W-1:0]   ex_op,
   input  logic              ex_we,
   input  logic [REG_AW-1:0] ex_rd,
   output logic              load_use,
   output logic              stall_f
);

   // Load-use compare; rt only matters for ops that actually read it.
   always_comb begin
      load_use = valid_d & ~halted & ex_valid & (ex_op == OP_LD) & ex_we &
                 ((ex_rd == rs) | ((ex_rd == rt) & uses_rt(op)));
   end

   // Fetch holds on a load-use bubble or forever once halted; never in reset.
   always_comb begin
      stall_f = ~rst & (halted | load_use);
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: field decode, load-use / halt stall generation
// and the ID/EX pipeline register.
//
// state   | meaning
// RUN_ST  | decoding normally
// HALT_ST | HALT accepted; fetch frozen, ID/EX fed bubbles until reset
module decode_stage
   import cpu_pkg::*;
#(
   parameter int BUS_WIDTH = 32,
   parameter int REG_AW    = 5,
   parameter int OP_W      = 6
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] instr_d,
   input  logic [BUS_WIDTH-1:0] pc_d,
   input  logic                 valid_d,
   output logic                 stall_f,
   output logic [REG_AW-1:0]    rf_ra1,
   output logic [REG_AW-1:0]    rf_ra2,
   output logic                 ex_valid,
   output logic [OP_W-1:0]      ex_op,
   output logic [REG_AW-1:0]    ex_rd,
   output logic [REG_AW-1:0]    ex_rs,
   output logic [REG_AW-1:0]    ex_rt,
   output logic [BUS_WIDTH-1:0] ex_imm,
   output logic [BUS_WIDTH-1:0] ex_pc,
   output logic                 ex_we,
   output logic                 halted,
   output logic                 illegal,
   output logic [BUS_WIDTH-1:0] stall_cnt
);

   logic [OP_W-1:0]      op;
   logic [REG_AW-1:0]    rd;
   logic [REG_AW-1:0]    rs;
   logic [REG_AW-1:0]    rt;
   logic [BUS_WIDTH-1:0] imm_sx;
   logic                 load_use;
   logic                 op_legal;
   logic                 accept;
   run_state_e           state;
   run_state_e           state_nxt;

   // Field extraction and sign extension straight off the IF/ID register.
   always_comb begin
      op       = instr_d[OP_HI:OP_LO];
      rd       = instr_d[RD_HI:RD_LO];
      rs       = instr_d[RS_HI:RS_LO];
      rt       = instr_d[RT_HI:RT_LO];
      imm_sx   = {{(BUS_WIDTH-16){instr_d[IMM_HI]}}, instr_d[IMM_HI:IMM_LO]};
      op_legal = is_legal(op);
      rf_ra1   = rs;
      rf_ra2   = rt;
   end

   hazard_unit #(
      .REG_AW (REG_AW),
      .OP_W   (OP_W)
   ) u_hazard (
      .rst      (RST),
      .halted   (halted),
      .valid_d  (valid_d),
      .op       (op),
      .rs       (rs),
      .rt       (rt),
      .ex_valid (ex_valid),
      .ex_op    (ex_op),
      .ex_we    (ex_we),
      .ex_rd    (ex_rd),
      .load_use (load_use),
      .stall_f  (stall_f)
   );

   // An instruction is consumed when it is real, not stalled and not frozen.
   always_comb begin
      accept = valid_d & ~halted & ~load_use;
   end

   // Run/halt state register.
   always_ff @(posedge CLK) begin
      if (RST) state <= RUN_ST;
      else     state <= state_nxt;
   end

   // Halt is entered on the edge that loads a consumed HALT into ID/EX.
   always_comb begin
      state_nxt = state;
      if ((state == RUN_ST) && accept && (op == OP_HALT))
         state_nxt = HALT_ST;
   end

   // Halted flag decoded from state.
   always_comb begin
      halted = (state == HALT_ST);
   end

   // ID/EX register: bubble (all zero) unless a legal instruction is consumed.
   always_ff @(posedge CLK) begin
      if (RST || !(accept && op_legal)) begin
         ex_valid <= 1'b0;
         ex_op    <= '0;
         ex_rd    <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_imm   <= '0;
         ex_pc    <= '0;
         ex_we    <= 1'b0;
      end else begin
         ex_valid <= 1'b1;
         ex_op    <= op;
         ex_rd    <= rd;
         ex_rs    <= rs;
         ex_rt    <= rt;
         ex_imm   <= imm_sx;
         ex_pc    <= pc_d;
         ex_we    <= writes_rd(op) & (rd != '0);
      end
   end

   // Sticky illegal flag, set only when the unknown opcode is actually consumed.
   always_ff @(posedge CLK) begin
      if (RST)                     illegal <= 1'b0;
      else if (accept && !op_legal) illegal <= 1'b1;
   end

   // Counts load-use bubbles only; halt bubbles are not counted.
   always_ff @(posedge CLK) begin
      if (RST)           stall_cnt <= '0;
      else if (load_use) stall_cnt <= stall_cnt + BUS_WIDTH'(1);
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run compared against a behavioural model of the decode rules.
module tb_decode_stage;

   logic        CLK;
   logic        RST;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic        valid_d;
   logic        stall_f;
   logic [4:0]  rf_ra1;
   logic [4:0]  rf_ra2;
   logic        ex_valid;
   logic [5:0]  ex_op;
   logic [4:0]  ex_rd;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic [31:0] ex_imm;
   logic [31:0] ex_pc;
   logic        ex_we;
   logic        halted;
   logic        illegal;
   logic [31:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   decode_stage dut (
      .CLK       (CLK),
      .RST       (RST),
      .instr_d   (instr_d),
      .pc_d      (pc_d),
      .valid_d   (valid_d),
      .stall_f   (stall_f),
      .rf_ra1    (rf_ra1),
      .rf_ra2    (rf_ra2),
      .ex_valid  (ex_valid),
      .ex_op     (ex_op),
      .ex_rd     (ex_rd),
      .ex_rs     (ex_rs),
      .ex_rt     (ex_rt),
      .ex_imm    (ex_imm),
      .ex_pc     (ex_pc),
      .ex_we     (ex_we),
      .halted    (halted),
      .illegal   (illegal),
      .stall_cnt (stall_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   logic        m_valid, m_we, m_halted, m_illegal, e_stall;
   logic [5:0]  m_op;
   logic [4:0]  m_rd, m_rs, m_rt;
   logic [31:0] m_imm, m_pc, m_cnt;

   function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] lo);
      return {op, rd, rs, lo};
   endfunction

   function automatic logic m_legal(input logic [5:0] op);
      return (op <= 6'd7) || (op == 6'h3F);
   endfunction

   function automatic logic m_reads_rt(input logic [5:0] op);
      return (op == 6'd1) || (op == 6'd2) || (op == 6'd3) || (op == 6'd4) || (op == 6'd6);
   endfunction

   function automatic logic m_writes(input logic [5:0] op);
      return (op >= 6'd1 && op <= 6'd5) || (op == 6'd7);
   endfunction

   function automatic logic m_hazard();
      logic [5:0] op;
      logic [4:0] rs, rt;
      op = instr_d[31:26];
      rs = instr_d[20:16];
      rt = instr_d[15:11];
      return valid_d && m_valid && (m_op == 6'd5) && m_we &&
             ((m_rd == rs) || ((m_rd == rt) && m_reads_rt(op)));
   endfunction

   task automatic model_next();
      logic lu;
      lu = m_hazard();
      if (RST) begin
         {m_valid, m_op, m_rd, m_rs, m_rt, m_imm, m_pc, m_we} = '0;
         m_halted = 0; m_illegal = 0; m_cnt = 0;
      end else if (m_halted || !valid_d || lu || !m_legal(instr_d[31:26])) begin
         if (!m_halted && valid_d && !lu) m_illegal = 1;
         if (!m_halted && lu) m_cnt = m_cnt + 1;
         {m_valid, m_op, m_rd, m_rs, m_rt, m_imm, m_pc, m_we} = '0;
      end else begin
         m_valid = 1;
         m_op    = instr_d[31:26];
         m_rd    = instr_d[25:21];
         m_rs    = instr_d[20:16];
         m_rt    = instr_d[15:11];
         m_imm   = 32'(signed'(instr_d[15:0]));
         m_pc    = pc_d;
         m_we    = m_writes(m_op) && (m_rd != 0);
         if (m_op == 6'h3F) m_halted = 1;
      end
   endtask

   task automatic drive(input logic [31:0] i, input logic v);
      @(negedge CLK);
      instr_d = i;
      valid_d = v;
      pc_d    = $urandom;
      #1;
      e_stall = !RST && (m_halted || m_hazard());
   endtask

   task automatic tick();
      model_next();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- directed tests ----------------
   task automatic test_reset();
      RST = 1;
      drive(32'hFFFF_FFFF, 1);
      n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_f); end
      tick();
      drive(32'h0, 0);
      tick();
      n_cmp++;
      if ({ex_valid, ex_op, ex_rd, ex_imm, ex_pc, ex_we, halted, illegal, stall_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got v=%b op=%h rd=%h imm=%h pc=%h we=%b h=%b i=%b cnt=%0d want all 0",
                  ex_valid, ex_op, ex_rd, ex_imm, ex_pc, ex_we, halted, illegal, stall_cnt);
      end
      RST = 0;
   endtask

   task automatic test_add();
      logic [31:0] pc;
      drive(32'h04611000, 1);
      pc = pc_d;
      n_cmp++; if ({rf_ra1, rf_ra2} !== {5'd1, 5'd2}) begin n_err++; $display("FAIL add_raddr: got %0d/%0d want 1/2", rf_ra1, rf_ra2); end
      n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL add_stall: got %b want 0", stall_f); end
      tick();
      n_cmp++;
      if ({ex_valid, ex_op, ex_rd, ex_rs, ex_rt, ex_we} !== {1'b1, 6'd1, 5'd3, 5'd1, 5'd2, 1'b1}) begin
         n_err++;
         $display("FAIL add_decode: got v=%b op=%0d rd=%0d rs=%0d rt=%0d we=%b want 1/1/3/1/2/1",
                  ex_valid, ex_op, ex_rd, ex_rs, ex_rt, ex_we);
      end
      n_cmp++; if (ex_pc !== pc) begin n_err++; $display("FAIL add_pc: got %h want %h", ex_pc, pc); end
   endtask

   task automatic test_addi();
      drive(enc(6'd7, 5'd4, 5'd0, 16'hFFFE), 1);
      tick();
      n_cmp++;
      if ({ex_imm, ex_we, ex_rd} !== {32'hFFFF_FFFE, 1'b1, 5'd4}) begin
         n_err++; $display("FAIL addi_sext: got imm=%h we=%b rd=%0d want FFFFFFFE/1/4", ex_imm, ex_we, ex_rd);
      end
      drive(enc(6'd7, 5'd4, 5'd0, 16'h7FFF), 1);
      tick();
      n_cmp++; if (ex_imm !== 32'h0000_7FFF) begin n_err++; $display("FAIL addi_pos: got %h want 00007FFF", ex_imm); end
   endtask

   task automatic test_load_use();
      drive(enc(6'd5, 5'd5, 5'd1, 16'h0), 1);
      tick();
      drive(enc(6'd1, 5'd6, 5'd5, {5'd2, 11'd0}), 1);
      n_cmp++; if (stall_f !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", stall_f); end
      tick();
      n_cmp++;
      if ({ex_valid, ex_we, ex_op, stall_cnt} !== {1'b0, 1'b0, 6'd0, 32'd1}) begin
         n_err++; $display("FAIL lu_bubble: got v=%b we=%b op=%0d cnt=%0d want 0/0/0/1", ex_valid, ex_we, ex_op, stall_cnt);
      end
      drive(instr_d, 1);
      n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", stall_f); end
      tick();
      n_cmp++;
      if ({ex_valid, ex_op, ex_rd} !== {1'b1, 6'd1, 5'd6}) begin
         n_err++; $display("FAIL lu_replay: got v=%b op=%0d rd=%0d want 1/1/6", ex_valid, ex_op, ex_rd);
      end
   endtask

   task automatic test_store_use();
      drive(enc(6'd5, 5'd5, 5'd0, 16'h0), 1);
      tick();
      drive(enc(6'd6, 5'd0, 5'd1, {5'd5, 11'd0}), 1);
      n_cmp++; if (stall_f !== 1'b1) begin n_err++; $display("FAIL st_stall: got %b want 1", stall_f); end
      tick();
      n_cmp++; if (stall_cnt !== 32'd2) begin n_err++; $display("FAIL st_cnt: got %0d want 2", stall_cnt); end
      drive(instr_d, 1);
      tick();
      n_cmp++;
      if ({ex_valid, ex_op, ex_we} !== {1'b1, 6'd6, 1'b0}) begin
         n_err++; $display("FAIL st_decode: got v=%b op=%0d we=%b want 1/6/0", ex_valid, ex_op, ex_we);
      end
   endtask

   task automatic test_rd_zero();
      drive(enc(6'd5, 5'd0, 5'd1, 16'h0), 1);
      tick();
      n_cmp++; if ({ex_valid, ex_we} !== 2'b10) begin n_err++; $display("FAIL ld_r0_we: got v=%b we=%b want 1/0", ex_valid, ex_we); end
      drive(enc(6'd1, 5'd7, 5'd0, {5'd3, 11'd0}), 1);
      n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL ld_r0_stall: got %b want 0", stall_f); end
      tick();
      n_cmp++; if ({ex_valid, stall_cnt} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL ld_r0_pass: got v=%b cnt=%0d want 1/2", ex_valid, stall_cnt); end
   endtask

   task automatic test_illegal_nop();
      drive(enc(6'h20, 5'd1, 5'd2, 16'h1234), 1);
      n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL ill_stall: got %b want 0", stall_f); end
      tick();
      n_cmp++; if ({illegal, ex_valid, ex_op} !== {1'b1, 1'b0, 6'd0}) begin n_err++; $display("FAIL ill_flag: got i=%b v=%b op=%0d want 1/0/0", illegal, ex_valid, ex_op); end
      drive(32'h0, 1);
      tick();
      n_cmp++;
      if ({ex_valid, ex_op, ex_we, illegal} !== {1'b1, 6'd0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL zero_nop: got v=%b op=%0d we=%b i=%b want 1/0/0/1", ex_valid, ex_op, ex_we, illegal);
      end
      drive(32'h04611000, 0);
      tick();
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL invalid_bubble: got %b want 0", ex_valid); end
   endtask

   task automatic test_halt();
      logic [31:0] cnt0;
      cnt0 = stall_cnt;
      drive(32'hFC00_0000, 1);
      n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL halt_pre: got %b want 0", stall_f); end
      tick();
      n_cmp++;
      if ({halted, ex_valid, ex_op, ex_we} !== {1'b1, 1'b1, 6'h3F, 1'b0}) begin
         n_err++; $display("FAIL halt_load: got h=%b v=%b op=%h we=%b want 1/1/3F/0", halted, ex_valid, ex_op, ex_we);
      end
      for (int k = 0; k < 12; k++) begin
         drive($urandom, 1);
         n_cmp++; if (stall_f !== 1'b1) begin n_err++; $display("FAIL halt_stall[%0d]: got %b want 1", k, stall_f); end
         tick();
         n_cmp++;
         if ({ex_valid, stall_cnt} !== {1'b0, cnt0}) begin
            n_err++; $display("FAIL halt_bubble[%0d]: got v=%b cnt=%0d want 0/%0d", k, ex_valid, stall_cnt, cnt0);
         end
      end
      RST = 1;
      drive(32'h04611000, 1);
      n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL halt_rst_stall: got %b want 0", stall_f); end
      tick();
      RST = 0;
      n_cmp++; if ({halted, illegal, stall_cnt} !== '0) begin n_err++; $display("FAIL halt_rst: got h=%b i=%b cnt=%0d want 0", halted, illegal, stall_cnt); end
      drive(32'h04611000, 1);
      n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL post_rst_stall: got %b want 0", stall_f); end
      tick();
      n_cmp++; if ({ex_valid, ex_op} !== {1'b1, 6'd1}) begin n_err++; $display("FAIL post_rst_decode: got v=%b op=%0d want 1/1", ex_valid, ex_op); end
   endtask

   task automatic test_halt_precedence();
      drive(enc(6'd5, 5'd5, 5'd1, 16'h0), 1);
      tick();
      drive(enc(6'h3F, 5'd0, 5'd5, 16'h0), 1);
      n_cmp++; if (stall_f !== 1'b1) begin n_err++; $display("FAIL hp_stall: got %b want 1", stall_f); end
      tick();
      n_cmp++; if ({halted, ex_valid, stall_cnt} !== {1'b0, 1'b0, 32'd1}) begin n_err++; $display("FAIL hp_bubble: got h=%b v=%b cnt=%0d want 0/0/1", halted, ex_valid, stall_cnt); end
      drive(instr_d, 1);
      tick();
      n_cmp++; if ({halted, ex_valid, ex_op} !== {1'b1, 1'b1, 6'h3F}) begin n_err++; $display("FAIL hp_halt: got h=%b v=%b op=%h want 1/1/3F", halted, ex_valid, ex_op); end
      RST = 1;
      drive(32'h0, 0);
      tick();
      RST = 0;
   endtask

   task automatic test_random();
      logic [5:0]  op;
      logic [31:0] ins;
      int k;
      for (int n = 0; n < 600; n++) begin
         RST = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 7) == 0);
         k = $urandom_range(0, 11);
         if (k <= 7)      op = 6'(k);
         else if (k == 8) op = 6'd5;
         else if (k == 9) op = ($urandom_range(0, 4) == 0) ? 6'h3F : 6'd5;
         else             op = 6'($urandom_range(8, 62));
         ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
         drive(ins, $urandom_range(0, 9) != 0);
         n_cmp++;
         if ({stall_f, rf_ra1, rf_ra2} !== {e_stall, ins[20:16], ins[15:11]}) begin
            n_err++; $display("FAIL rnd_comb[%0d]: got st=%b ra=%0d/%0d want %b/%0d/%0d",
                              n, stall_f, rf_ra1, rf_ra2, e_stall, ins[20:16], ins[15:11]);
         end
         tick();
         n_cmp++;
         if ({ex_valid, ex_op, ex_rd, ex_rs, ex_rt, ex_imm, ex_pc, ex_we, halted, illegal, stall_cnt} !==
             {m_valid, m_op, m_rd, m_rs, m_rt, m_imm, m_pc, m_we, m_halted, m_illegal, m_cnt}) begin
            n_err++;
            $display("FAIL rnd_state[%0d]: got v=%b op=%h rd=%0d rs=%0d rt=%0d imm=%h pc=%h we=%b h=%b i=%b cnt=%0d want v=%b op=%h rd=%0d rs=%0d rt=%0d imm=%h pc=%h we=%b h=%b i=%b cnt=%0d",
                     n, ex_valid, ex_op, ex_rd, ex_rs, ex_rt, ex_imm, ex_pc, ex_we, halted, illegal, stall_cnt,
                     m_valid, m_op, m_rd, m_rs, m_rt, m_imm, m_pc, m_we, m_halted, m_illegal, m_cnt);
         end
      end
      RST = 0;
   endtask

   initial begin
      RST     = 1;
      instr_d = '0;
      pc_d    = '0;
      valid_d = 0;
      test_reset();
      test_add();
      test_addi();
      test_load_use();
      test_store_use();
      test_rd_zero();
      test_illegal_nop();
      test_halt();
      test_halt_precedence();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
